multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
- Parametrised multi-channel timer; the next generation of the single 64-bit timer used by the test-shield peripherals.
- Provides NUM_CH independent channels, each with its own mode, enable, and reload value.
- A shared prescaler generates the count tick.
- Adds four things the single timer lacked: periodic auto-reload with an expiry pulse, saturating elapsed count with a sticky overflow flag, enable-edge counting, and a per-channel synchronous load.

Parameters:
NUM_CH, 4, number of independent channels
WIDTH, 32, counter width per channel
PRESCALE_W, 8, width of the shared prescale divider

Ports:
clk  in  1  system clock (100 MHz, 10 ns)
rst_n  in  1  asynchronous active-low reset
prescale  in  PRESCALE_W  tick generated every prescale+1 clk cycles
ch_load  in  NUM_CH  per-channel synchronous (re)initialise
ch_mode  in  2*NUM_CH  per-channel mode; channel i uses bits [2i+1:2i]
ch_enable  in  NUM_CH  per-channel count enable
ch_count_once  in  NUM_CH  elapsed mode: measure only the first enable pulse
ch_reload  in  WIDTH*NUM_CH  countdown/period value; channel i uses slice i
ch_counter  out  WIDTH*NUM_CH  current counter per channel (registered)
ch_pending  out  NUM_CH  countdown still running
ch_expire  out  NUM_CH  one-clk pulse on countdown/period expiry (registered)
ch_overflow  out  NUM_CH  sticky saturation flag (elapsed/edge modes)

Behaviour:
- Async reset (rst_n=0), effective immediately without a clock edge:
  - ch_counter=0, ch_expire=0, ch_overflow=0
  - internal armed=1, enable_prev=0, pre_cnt=0
  - ch_pending=0 follows, since pending is derived from counter=0.
- Prescaler:
  - pre_cnt runs free.
  - tick=1 in any cycle where pre_cnt>=prescale; pre_cnt then returns to 0, otherwise it increments.
  - prescale=0 gives a tick on every clk.
  - Lowering prescale below pre_cnt gives a tick on the next cycle; there is no wrap.
- enable_prev[i] samples ch_enable[i] on every clk, regardless of load or mode.
  - rise = enable & ~enable_prev
  - fall = ~enable & enable_prev
- ch_load[i] takes priority over all other activity on channel i in that cycle:
  - Modes 00/11: counter=0.
  - Modes 01/10: counter=reload.
  - Always: armed=1, overflow=0, expire=0.
- Mode 00 ELAPSED:
  - On tick & enable & armed: counter+1.
  - At all-ones the counter holds and overflow is set.
  - When count_once=1 and fall occurs, armed is cleared until the next load.
  - pending=0.
- Mode 01 ONESHOT:
  - On tick & enable & counter!=0: counter-1.
  - On the 1→0 transition, expire is pulsed high for exactly one clk, in the same cycle the counter first reads 0.
  - pending = (counter!=0).
  - reload=0 gives no countdown and no expire.
- Mode 10 PERIODIC:
  - Same as ONESHOT, except that a decrement from 1 reloads the counter with reload instead of going to 0, and pulses expire.
  - Sequence for reload=R: R, R-1, …, 1, R; period = R ticks.
  - reload=0: channel idles at 0 with no expire.
  - A reload value changed mid-period takes effect at the next wrap.
  - pending = (counter!=0).
- Mode 11 EDGE_COUNT:
  - counter+1 on each rise; the prescaler tick is ignored.
  - Saturates at all-ones and sets overflow.
  - pending=0.
- Mode change without load:
  - The counter is kept; the new mode's rules apply from the next cycle.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Latency:
  - Every output is registered; a change is visible one clk after the causing edge.
  - Exception: pending is combinational from the counter.

Decomposition:
- Package multi_timer_pkg:
  - MODE_ELAPSED=2'b00, MODE_ONESHOT=2'b01, MODE_PERIODIC=2'b10, MODE_EDGE_COUNT=2'b11.
  - Shared parameter defaults.
- Sub-module timer_channel (params WIDTH):
  - Holds one counter, armed, enable_prev, expire, overflow.
  - Takes tick as an input.
- Top level:
  - Holds the prescaler.
  - Instantiates NUM_CH copies via a generate loop.
  - Slices the flattened buses.

Test Plan:
- ELAPSED, prescale=0, count_once=1, enable high 10 clks then low, second 5-clk pulse -> counter=10 after the first pulse, still 10 after the second; load -> 0.
- ONESHOT, reload=5, prescale=0, enable held -> counter 5,4,3,2,1,0 on successive clks; expire high exactly one clk with counter=0; pending falls in that cycle.
- PERIODIC, reload=3, prescale=1 -> counter sequence 3,3,2,2,1,1,3…; expire every 6 clks; 4 consecutive periods checked.
- WIDTH=8 instance, ELAPSED, 260 ticks -> counter=255, overflow=1 and sticky; ch_load -> counter=0, overflow=0.
- EDGE_COUNT on ch2 with 7 enable pulses while ch0 runs ONESHOT reload=100 -> ch2=7; ch0 unaffected and correct.
- rst_n asserted mid-countdown (counter=40) between clk edges -> all outputs 0 immediately; ch_load coincident with tick in PERIODIC -> counter=reload (load wins) and no expire.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - mode encodings and parameter defaults for multi_timer
package multi_timer_pkg;

  localparam logic [1:0] MODE_ELAPSED    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT    = 2'b01;
  localparam logic [1:0] MODE_PERIODIC   = 2'b10;
  localparam logic [1:0] MODE_EDGE_COUNT = 2'b11;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/multi_timer_channel.sv
// rtl/multi_timer_channel.sv - one timer channel: counter, arm, edge history, expire, overflow
import multi_timer_pkg::*;

module timer_channel #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             enable,
  input  logic             count_once,
  input  logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] counter,
  output logic             pending,
  output logic             expire,
  output logic             overflow
);

  logic armed;
  logic enable_prev;
  logic rise;
  logic fall;
  logic at_max;
  logic at_one;
  logic is_countdown;

  assign rise         = enable & ~enable_prev;
  assign fall         = ~enable & enable_prev;
  assign at_max       = &counter;
  assign at_one       = (counter == WIDTH'(1));
  assign is_countdown = (mode == MODE_ONESHOT) || (mode == MODE_PERIODIC);
  // Pending is the only unregistered output: it tracks the counter directly.
  assign pending      = is_countdown && (counter != '0);

  // Enable history for edge detection, sampled unconditionally every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) enable_prev <= 1'b0;
    else        enable_prev <= enable;
  end

  // Counter, arm, expire and overflow update; load overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      armed    <= 1'b1;
      expire   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (load) begin
        counter  <= is_countdown ? reload : '0;
        armed    <= 1'b1;
        overflow <= 1'b0;
      end else begin
        case (mode)
          MODE_ELAPSED: begin
            if (tick && enable && armed) begin
              if (at_max) overflow <= 1'b1;
              else        counter  <= counter + WIDTH'(1);
            end
            if (count_once && fall) armed <= 1'b0;
          end
          MODE_ONESHOT: begin
            if (tick && enable && (counter != '0)) begin
              counter <= counter - WIDTH'(1);
              if (at_one) expire <= 1'b1;
            end
          end
          MODE_PERIODIC: begin
            if (tick && enable && (counter != '0)) begin
              if (at_one) begin
                counter <= reload;
                expire  <= 1'b1;
              end else begin
                counter <= counter - WIDTH'(1);
              end
            end
          end
          default: begin
            if (rise) begin
              if (at_max) overflow <= 1'b1;
              else        counter  <= counter + WIDTH'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - shared prescaler driving NUM_CH independent timer channels
import multi_timer_pkg::*;

module multi_timer #(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PRESCALE_W-1:0]   prescale,
  input  logic [NUM_CH-1:0]       ch_load,
  input  logic [2*NUM_CH-1:0]     ch_mode,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH-1:0]       ch_count_once,
  input  logic [WIDTH*NUM_CH-1:0] ch_reload,
  output logic [WIDTH*NUM_CH-1:0] ch_counter,
  output logic [NUM_CH-1:0]       ch_pending,
  output logic [NUM_CH-1:0]       ch_expire,
  output logic [NUM_CH-1:0]       ch_overflow
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;

  // Using >= lets a lowered prescale fire on the next cycle instead of wrapping.
  assign tick = (pre_cnt >= prescale);

  // Free-running prescale divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRESCALE_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .load       (ch_load[i]),
      .mode       (ch_mode[2*i +: 2]),
      .enable     (ch_enable[i]),
      .count_once (ch_count_once[i]),
      .reload     (ch_reload[WIDTH*i +: WIDTH]),
      .counter    (ch_counter[WIDTH*i +: WIDTH]),
      .pending    (ch_pending[i]),
      .expire     (ch_expire[i]),
      .overflow   (ch_overflow[i])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - scoreboard bench for multi_timer with a behavioural reference model
module tb_multi_timer;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     prescale = '0;
  logic [NCH-1:0] ch_load = '0;
  logic [2*NCH-1:0] ch_mode = '0;
  logic [NCH-1:0] ch_enable = '0;
  logic [NCH-1:0] ch_count_once = '0;
  logic [W*NCH-1:0] ch_reload = '0;
  logic [W*NCH-1:0] ch_counter;
  logic [NCH-1:0] ch_pending;
  logic [NCH-1:0] ch_expire;
  logic [NCH-1:0] ch_overflow;

  logic [7:0] w8_prescale = '0;
  logic       w8_load = 1'b0;
  logic [1:0] w8_mode = 2'b00;
  logic       w8_enable = 1'b0;
  logic       w8_count_once = 1'b0;
  logic [7:0] w8_reload = '0;
  logic [7:0] w8_counter;
  logic       w8_pending;
  logic       w8_expire;
  logic       w8_overflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_timer u_dut (
    .clk(clk), .rst_n(rst_n), .prescale(prescale), .ch_load(ch_load), .ch_mode(ch_mode),
    .ch_enable(ch_enable), .ch_count_once(ch_count_once), .ch_reload(ch_reload),
    .ch_counter(ch_counter), .ch_pending(ch_pending), .ch_expire(ch_expire),
    .ch_overflow(ch_overflow)
  );

  multi_timer #(.NUM_CH(1), .WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .prescale(w8_prescale), .ch_load(w8_load), .ch_mode(w8_mode),
    .ch_enable(w8_enable), .ch_count_once(w8_count_once), .ch_reload(w8_reload),
    .ch_counter(w8_counter), .ch_pending(w8_pending), .ch_expire(w8_expire),
    .ch_overflow(w8_overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [W*NCH-1:0] cnt;
    logic [NCH-1:0]   exp;
    logic [NCH-1:0]   ovf;
    logic [NCH-1:0]   pend;
  } exp_t;

  exp_t   sb_q[$];
  int     m_since;
  longint m_cnt[NCH];
  bit     m_armed[NCH];
  bit     m_prev[NCH];
  bit     m_ovf[NCH];
  bit     m_exp[NCH];

  task automatic model_step();
    exp_t   e;
    bit     tk;
    int     md;
    bit     en;
    bit     rise;
    bit     fall;
    longint r;
    longint top;
    top = (longint'(1) << W) - 1;
    if (!rst_n) begin
      m_since = 0;
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_armed[c] = 1; m_prev[c] = 0; m_ovf[c] = 0; m_exp[c] = 0;
      end
    end else begin
      tk = (m_since >= int'(prescale));
      m_since = tk ? 0 : m_since + 1;
      for (int c = 0; c < NCH; c++) begin
        md   = int'(ch_mode[2*c +: 2]);
        en   = ch_enable[c];
        r    = longint'(ch_reload[W*c +: W]);
        rise = en && !m_prev[c];
        fall = !en && m_prev[c];
        m_prev[c] = en;
        m_exp[c]  = 0;
        if (ch_load[c]) begin
          m_cnt[c]   = (md == 1 || md == 2) ? r : 0;
          m_armed[c] = 1;
          m_ovf[c]   = 0;
        end else if (md == 0) begin
          if (tk && en && m_armed[c]) begin
            if (m_cnt[c] == top) m_ovf[c] = 1; else m_cnt[c]++;
          end
          if (ch_count_once[c] && fall) m_armed[c] = 0;
        end else if (md == 3) begin
          if (rise) begin
            if (m_cnt[c] == top) m_ovf[c] = 1; else m_cnt[c]++;
          end
        end else if (tk && en && m_cnt[c] > 0) begin
          if (m_cnt[c] == 1) m_exp[c] = 1;
          m_cnt[c] = (m_cnt[c] == 1 && md == 2) ? r : m_cnt[c] - 1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      md = int'(ch_mode[2*c +: 2]);
      e.cnt[W*c +: W] = m_cnt[c][W-1:0];
      e.exp[c]  = m_exp[c];
      e.ovf[c]  = m_ovf[c];
      e.pend[c] = (md == 1 || md == 2) && (m_cnt[c] != 0);
    end
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int c = 0; c < NCH; c++)
        chk($sformatf("sb_ch%0d_counter", c), 64'(ch_counter[W*c +: W]), 64'(e.cnt[W*c +: W]));
      chk("sb_expire",   64'(ch_expire),   64'(e.exp));
      chk("sb_overflow", 64'(ch_overflow), 64'(e.ovf));
      chk("sb_pending",  64'(ch_pending),  64'(e.pend));
    end
  end

  // ---------------- stimulus ----------------
  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_all();
    ch_load = '0; ch_enable = '0; ch_count_once = '0; ch_mode = '0; prescale = '0;
  endtask

  int exp_at[$];
  bit found;

  initial begin
    #1;
    chk("reset_counter",  64'(ch_counter),  64'd0);
    chk("reset_expire",   64'(ch_expire),   64'd0);
    chk("reset_overflow", 64'(ch_overflow), 64'd0);
    chk("reset_pending",  64'(ch_pending),  64'd0);
    nclk(2);
    rst_n = 1'b1;

    // ELAPSED, count_once: second pulse must not count
    ch_mode[1:0] = 2'b00; ch_count_once[0] = 1'b1; ch_load[0] = 1'b1;
    nclk(1);
    ch_load[0] = 1'b0; ch_enable[0] = 1'b1;
    nclk(10);
    ch_enable[0] = 1'b0;
    nclk(1);
    chk("elapsed_first_pulse", 64'(ch_counter[31:0]), 64'd10);
    nclk(2);
    ch_enable[0] = 1'b1;
    nclk(5);
    ch_enable[0] = 1'b0;
    nclk(2);
    chk("elapsed_once_hold", 64'(ch_counter[31:0]), 64'd10);
    ch_load[0] = 1'b1;
    nclk(1);
    ch_load[0] = 1'b0;
    chk("elapsed_load_clear", 64'(ch_counter[31:0]), 64'd0);

    // ONESHOT reload=5
    ch_count_once = '0; ch_mode[1:0] = 2'b01; ch_reload[31:0] = 32'd5; ch_load[0] = 1'b1;
    nclk(1);
    ch_load[0] = 1'b0; ch_enable[0] = 1'b1;
    chk("oneshot_loaded", 64'(ch_counter[31:0]), 64'd5);
    for (int k = 4; k >= 0; k--) begin
      nclk(1);
      chk($sformatf("oneshot_cnt_%0d", k), 64'(ch_counter[31:0]), 64'(k));
      chk($sformatf("oneshot_exp_%0d", k), 64'(ch_expire[0]), 64'(k == 0));
    end
    chk("oneshot_pending_fall", 64'(ch_pending[0]), 64'd0);
    nclk(1);
    chk("oneshot_expire_single", 64'(ch_expire[0]), 64'd0);
    idle_all();

    // PERIODIC reload=3, prescale=1: expire every 6 clks
    prescale = 8'd1; ch_mode[3:2] = 2'b10; ch_reload[63:32] = 32'd3; ch_load[1] = 1'b1;
    nclk(1);
    ch_load[1] = 1'b0; ch_enable[1] = 1'b1;
    for (int k = 0; k < 36; k++) begin
      nclk(1);
      if (ch_expire[1]) exp_at.push_back(k);
    end
    chk("periodic_expire_count", 64'(exp_at.size() >= 5), 64'd1);
    for (int k = 1; k < 5 && k < exp_at.size(); k++)
      chk($sformatf("periodic_interval_%0d", k), 64'(exp_at[k] - exp_at[k-1]), 64'd6);
    idle_all();

    // EDGE_COUNT on ch2 with ch0 ONESHOT reload=100 running alongside
    ch_mode[1:0] = 2'b01; ch_reload[31:0] = 32'd100; ch_mode[5:4] = 2'b11;
    ch_load[0] = 1'b1; ch_load[2] = 1'b1;
    nclk(1);
    ch_load = '0; ch_enable[0] = 1'b1;
    for (int p = 0; p < 7; p++) begin
      ch_enable[2] = 1'b1; nclk(1);
      ch_enable[2] = 1'b0; nclk(1);
    end
    chk("edge_count_ch2", 64'(ch_counter[95:64]), 64'd7);
    chk("edge_ch0_unaffected", 64'(ch_counter[31:0]), 64'd86);
    idle_all();

    // load coincident with an expiring tick in PERIODIC: load wins
    ch_mode[3:2] = 2'b10; ch_reload[63:32] = 32'd2; ch_load[1] = 1'b1;
    nclk(1);
    ch_load[1] = 1'b0; ch_enable[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      nclk(1);
      if (ch_counter[63:32] == 32'd1) found = 1'b1;
    end
    chk("periodic_reach_one", 64'(found), 64'd1);
    ch_load[1] = 1'b1;
    nclk(1);
    ch_load[1] = 1'b0;
    chk("load_wins_counter", 64'(ch_counter[63:32]), 64'd2);
    chk("load_wins_no_expire", 64'(ch_expire[1]), 64'd0);
    idle_all();

    // async reset mid-countdown
    ch_mode[1:0] = 2'b01; ch_reload[31:0] = 32'd100; ch_load[0] = 1'b1;
    nclk(1);
    ch_load[0] = 1'b0; ch_enable[0] = 1'b1;
    nclk(60);
    chk("pre_reset_counter", 64'(ch_counter[31:0]), 64'd40);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_counter",  64'(ch_counter),  64'd0);
    chk("async_reset_pending",  64'(ch_pending),  64'd0);
    chk("async_reset_expire",   64'(ch_expire),   64'd0);
    chk("async_reset_overflow", 64'(ch_overflow), 64'd0);
    nclk(1);
    idle_all();
    rst_n = 1'b1;

    // randomized segments checked by the scoreboard
    for (int s = 0; s < 8; s++) begin
      prescale = 8'($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) begin
        ch_mode[2*c +: 2]   = 2'($urandom_range(0, 3));
        ch_reload[W*c +: W] = W'($urandom_range(0, 6));
        ch_count_once[c]    = 1'($urandom_range(0, 1));
      end
      ch_load = '1;
      nclk(1);
      ch_load = '0;
      for (int t = 0; t < 60; t++) begin
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 3) == 0)  ch_enable[c] = ~ch_enable[c];
          ch_load[c] = ($urandom_range(0, 24) == 0);
          if ($urandom_range(0, 29) == 0) ch_mode[2*c +: 2] = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 19) == 0) ch_reload[W*c +: W] = W'($urandom_range(0, 6));
        end
        if ($urandom_range(0, 39) == 0) prescale = 8'($urandom_range(0, 3));
        nclk(1);
      end
      ch_load = '0;
    end
    idle_all();

    // WIDTH=8 saturation and sticky overflow
    w8_load = 1'b1;
    nclk(1);
    w8_load = 1'b0; w8_enable = 1'b1;
    nclk(260);
    chk("w8_saturate_counter", 64'(w8_counter), 64'd255);
    chk("w8_overflow_set", 64'(w8_overflow), 64'd1);
    w8_enable = 1'b0;
    nclk(3);
    chk("w8_overflow_sticky", 64'(w8_overflow), 64'd1);
    w8_load = 1'b1;
    nclk(1);
    w8_load = 1'b0;
    chk("w8_load_counter", 64'(w8_counter), 64'd0);
    chk("w8_load_overflow", 64'(w8_overflow), 64'd0);

    nclk(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
